// File: rtl/vedic_mul8_seq.sv
// Sequential 8x8 unsigned Vedic multiplier: one 4x4 crosswise partial product per cycle.
// Optional completed-product counter on done_count when VEDIC_PERF_CNT_EN is defined.
module vedic_mul8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef VEDIC_PERF_CNT_EN
    output logic [7:0]  done_count,
`endif
    output logic [15:0] product
);

    // state  | meaning
    // S_IDLE | waiting for operands, in_ready high
    // S_MUL  | accumulating partial product step_q (0..3)
    // S_DONE | product valid, held until out_ready
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;

    logic [3:0]  nib_a, nib_b;
    logic [7:0]  pp;
    logic [11:0] addend;
    logic [11:0] sum;
    logic        carry;

    // step 1 and 3 use aH, step 2 and 3 use bH
    assign nib_a  = step_q[0] ? a_q[7:4] : a_q[3:0];
    assign nib_b  = step_q[1] ? b_q[7:4] : b_q[3:0];
    assign pp     = {4'h0, nib_a} * {4'h0, nib_b};
    assign addend = (step_q == 2'd3) ? {pp, 4'h0} : {4'h0, pp};

    always_comb begin
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sum[i] = acc_q[i+4] ^ addend[i] ^ carry;
            carry  = (acc_q[i+4] & addend[i]) | (carry & (acc_q[i+4] ^ addend[i]));
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    step_d  = 2'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (step_q == 2'd0) begin
                    acc_d = {8'h00, pp};
                end else begin
                    acc_d = {sum, acc_q[3:0]};
                end
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = acc_q;

`ifdef VEDIC_PERF_CNT_EN
    logic [7:0] done_count_q, done_count_d;

    assign done_count_d = (out_valid && out_ready) ? done_count_q + 8'd1 : done_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_count_q <= 8'h00;
        end else begin
            done_count_q <= done_count_d;
        end
    end

    assign done_count = done_count_q;
`endif

endmodule

// File: tb/tb_vedic_mul8_seq.sv
// Self-checking bench for vedic_mul8_seq; expected products come from plain a*b arithmetic.
module tb_vedic_mul8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
`ifdef VEDIC_PERF_CNT_EN
    logic [7:0]  done_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vedic_mul8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef VEDIC_PERF_CNT_EN
        .done_count(done_count),
`endif
        .product   (product)
    );

    always #5 clk = ~clk;

    // Drive an operand pair from a falling edge; returns after the accepting rising edge.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    // Counts falling edges after acceptance until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 8'h00; b = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h want 0000", product); end
`ifdef VEDIC_PERF_CNT_EN
        n_checks++;
        if (done_count !== 8'h00) begin n_fail++; $display("FAIL reset_done_count got %h want 00", done_count); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_latency();
        bit ok;
        int cyc;
        out_ready = 1'b1;
        start_op(8'h12, 8'h34, ok);
        wait_valid(cyc);
        n_checks++;
        if (cyc !== 5) begin n_fail++; $display("FAIL latency_cycles got %0d want 5", cyc); end
        n_checks++;
        if (product !== 16'h03A8) begin n_fail++; $display("FAIL latency_product got %h want 03a8", product); end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_return_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_corners();
        logic [7:0] ta [3] = '{8'hFF, 8'h00, 8'hF0};
        logic [7:0] tb [3] = '{8'hFF, 8'hA5, 8'h0F};
        bit ok;
        int cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], ok);
            wait_valid(cyc);
            n_checks++;
            if (cyc < 0 || product !== 16'(ta[i] * tb[i])) begin
                n_fail++;
                $display("FAIL corner_%0d got %h (cycles %0d) want %h", i, product, cyc, 16'(ta[i] * tb[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        int bad;
        out_ready = 1'b0;
        start_op(8'h0F, 8'hF0, ok);
        wait_valid(cyc);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            a = 8'h55; b = 8'hAA;
            @(negedge clk);
            if (out_valid !== 1'b1 || product !== 16'h0E10 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc < 0 || bad != 0) begin
            n_fail++; $display("FAIL backpressure_hold got %0d bad cycles, last product %h want 0 bad, 0e10", bad, product);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL backpressure_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int cyc;
        int pulses;
        out_ready = 1'b1;
        start_op(8'hAB, 8'hCD, ok);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || product !== 16'h0000 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_state got out_valid=%b product=%h in_ready=%b want 0/0000/1", out_valid, product, in_ready);
        end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL midreset_no_valid got %0d pulses want 0", pulses); end
        start_op(8'h03, 8'h05, ok);
        wait_valid(cyc);
        n_checks++;
        if (cyc !== 5 || product !== 16'h000F) begin
            n_fail++; $display("FAIL midreset_next_op got %h (cycles %0d) want 000f (5)", product, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q[$];
        int done;
        int bad;
        int budget;
        logic [15:0] e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        done = 0; bad = 0; budget = 0;
        while (done < 257 && budget < 257 * 6 + 50) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) bad++;
                else begin
                    e = exp_q.pop_front();
                    if (product !== e) bad++;
                end
                done++;
            end
            in_valid = (done + exp_q.size() < 257);
            a = 8'($urandom); b = 8'($urandom);
            if (in_valid && in_ready) exp_q.push_back(16'(a * b));
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (done != 257 || bad != 0) begin
            n_fail++; $display("FAIL b2b_products got %0d done, %0d bad want 257, 0", done, bad);
        end
`ifdef VEDIC_PERF_CNT_EN
        n_checks++;
        if (done_count !== 8'h01) begin n_fail++; $display("FAIL b2b_done_count got %h want 01", done_count); end
`endif
    endtask

    task automatic test_random_sweep();
        logic [15:0] exp_q[$];
        int accepted;
        int returned;
        int bad;
        int extra;
        int budget;
        logic [15:0] e;
        accepted = 0; returned = 0; bad = 0; extra = 0; budget = 0;
        @(negedge clk);
        while (budget < 40000 && (accepted < 3000 || exp_q.size() != 0)) begin
            out_ready = ($urandom_range(3) != 0) || (accepted >= 3000);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) extra++;
                else begin
                    e = exp_q.pop_front();
                    if (product !== e) begin
                        bad++;
                        if (bad < 5) $display("FAIL sweep_product got %h want %h", product, e);
                    end
                    returned++;
                end
            end
            in_valid = (accepted < 3000) && ($urandom_range(1) == 1);
            a = 8'($urandom); b = 8'($urandom);
            if (in_valid && in_ready) begin
                exp_q.push_back(16'(a * b));
                accepted++;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL sweep_mismatches got %0d want 0", bad); end
        n_checks++;
        if (returned != accepted || extra != 0 || accepted != 3000) begin
            n_fail++;
            $display("FAIL sweep_count got accepted=%0d returned=%0d extra=%0d want 3000/3000/0", accepted, returned, extra);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
